// File: rtl/step_pulse_gen_pkg.sv
// Package shared by the step pulse generator and its debouncer.
// Holds the FSM state encoding (also driven onto the debug LEDs),
// the synchronizer depth and the length of the post-reset arm window.
package step_pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT_REL = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    localparam int SYNC_STAGES = 2;

    // Number of clk after reset during which ticks and presses are ignored.
    localparam int ARM_CYCLES = 3;

endpackage : step_pulse_gen_pkg

// File: rtl/step_pulse_gen_debouncer.sv
// Pushbutton conditioner: synchronizes the raw button, debounces it and
// produces a registered one-clk strobe on each debounced 0->1 transition.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous, active-high; clears synchronizer, counter, level, strobe
//   din    in   raw button level, asynchronous and bouncy
//   dout   out  debounced button level
//   rise   out  one-clk strobe on a debounced 0->1 transition
module step_pulse_gen_debouncer
    import step_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise
);

    // One extra bit so the counter also fits DEBOUNCE_CYCLES=1.
    localparam int CNT_BITS = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_BITS-1:0]    cnt;
    logic                   level;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];
    assign dout   = level;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values; blocking would collapse the synchronizer chain.
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            rise <= 1'b0;
            if (synced != level) begin
                // Accept the new level only after DEBOUNCE_CYCLES
                // consecutive differing samples.
                if (cnt == CNT_LAST) begin
                    level <= synced;
                    cnt   <= '0;
                    rise  <= synced;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule : step_pulse_gen_debouncer

// File: rtl/step_pulse_gen.sv
// Step strobe generator for the multicycle CPU clock enable.
// Free-runs on rising edges of the divided slow clock level, or single-steps
// from a debounced pushbutton; a CPU halt freezes stepping until reset.
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high; clears all state
//   slow_lvl    in   divided-clock level, asynchronous to clk
//   btn_step    in   raw pushbutton, active-high, asynchronous and bouncy
//   auto_mode   in   1 = free-run on slow_lvl rises, 0 = manual button stepping
//   halt        in   synchronous halt request from the CPU
//   step_en     out  one-clk strobe, CPU advances one cycle
//   step_count  out  step_en pulses since reset, wraps modulo 2^CNT_W
//   state_dbg   out  FSM state encoding for LEDs
module step_pulse_gen
    import step_pulse_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             slow_lvl,
    input  logic             btn_step,
    input  logic             auto_mode,
    input  logic             halt,
    output logic             step_en,
    output logic [CNT_W-1:0] step_count,
    output logic [1:0]       state_dbg
);

    localparam logic [1:0] ARM_LAST = 2'(ARM_CYCLES);

    state_t                 state;
    state_t                 state_next;
    logic                   step_next;
    logic [SYNC_STAGES-1:0] slow_sync;
    logic                   slow_prev;
    logic [1:0]             arm_cnt;
    logic                   armed;
    logic                   tick;
    logic                   press;
    logic                   btn_level;

    step_pulse_gen_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk   (clk),
        .reset (reset),
        .din   (btn_step),
        .dout  (btn_level),
        .rise  (press)
    );

    // Ticks and presses are masked until the arm window has elapsed, so a
    // level already high when reset is released cannot produce a pulse.
    assign armed     = (arm_cnt == ARM_LAST);
    assign tick      = slow_sync[SYNC_STAGES-1] & ~slow_prev & armed;
    assign state_dbg = state;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        state_next = state;
        step_next  = 1'b0;
        if (halt) begin
            state_next = ST_HALTED;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (auto_mode) begin
                        state_next = ST_RUN;
                    end else if (press && armed) begin
                        step_next  = 1'b1;
                        state_next = ST_WAIT_REL;
                    end
                end
                ST_RUN: begin
                    // Leaving RUN drops a tick arriving in the same cycle.
                    if (!auto_mode) begin
                        state_next = ST_IDLE;
                    end else begin
                        step_next = tick;
                    end
                end
                ST_WAIT_REL: begin
                    if (!btn_level) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    state_next = ST_HALTED;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // step_en is registered, adding one clk after the 2-stage synchronizer:
    // a slow_lvl rise shows up on step_en three clk later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            step_en    <= 1'b0;
            step_count <= '0;
            slow_sync  <= '0;
            slow_prev  <= 1'b0;
            arm_cnt    <= '0;
        end else begin
            state     <= state_next;
            step_en   <= step_next;
            slow_sync <= {slow_sync[SYNC_STAGES-2:0], slow_lvl};
            slow_prev <= slow_sync[SYNC_STAGES-1];
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
            if (step_next) begin
                step_count <= step_count + 1'b1;
            end
        end
    end

endmodule : step_pulse_gen

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen with DEBOUNCE_CYCLES=4, CNT_W=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_step_pulse_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       slow_lvl;
    logic       btn_step;
    logic       auto_mode;
    logic       halt;
    logic       step_en;
    logic [3:0] step_count;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_err    = 0;
    int pulse_total = 0;
    int consec      = 0;
    bit prev_step   = 1'b0;
    int base;

    always #5 clk = ~clk;

    step_pulse_gen #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .slow_lvl   (slow_lvl),
        .btn_step   (btn_step),
        .auto_mode  (auto_mode),
        .halt       (halt),
        .step_en    (step_en),
        .step_count (step_count),
        .state_dbg  (state_dbg)
    );

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (step_en === 1'b1) begin
            pulse_total = pulse_total + 1;
            if (prev_step) consec = consec + 1;
        end
        prev_step = (step_en === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        slow_lvl  = 1'b0;
        btn_step  = 1'b0;
        auto_mode = 1'b1;
        halt      = 1'b0;
        cyc(2);
        check("reset_step_en", 32'(step_en), 32'd0);
        check("reset_count",   32'(step_count), 32'd0);
        check("reset_state",   32'(state_dbg), 32'd0);
        reset = 1'b0;

        // 1. free-run: pulse 3 clk after each rise
        cyc(4);
        check("t1_run_state", 32'(state_dbg), 32'd1);
        for (int i = 0; i < 3; i++) begin
            slow_lvl = 1'b1;
            cyc(2);
            check("t1_before", 32'(step_en), 32'd0);
            cyc(1);
            check("t1_pulse", 32'(step_en), 32'd1);
            check("t1_count", 32'(step_count), 32'(i + 1));
            cyc(1);
            check("t1_after", 32'(step_en), 32'd0);
            cyc(6);
            slow_lvl = 1'b0;
            cyc(10);
        end

        // 3. level high through reset: no spurious pulse
        slow_lvl = 1'b1;
        do_reset();
        base = pulse_total;
        cyc(15);
        check("t3_no_pulse", 32'(pulse_total - base), 32'd0);
        check("t3_count",    32'(step_count), 32'd0);
        check("t3_state",    32'(state_dbg), 32'd1);

        // 2. manual step with bouncy button
        auto_mode = 1'b0;
        cyc(2);
        check("t2_idle", 32'(state_dbg), 32'd0);
        base = pulse_total;
        btn_step = 1'b1;
        cyc(1);
        btn_step = 1'b0;
        cyc(1);
        btn_step = 1'b1;          // stable high begins
        cyc(6);
        check("t2_early", 32'(step_en), 32'd0);
        cyc(1);
        check("t2_pulse", 32'(step_en), 32'd1);
        check("t2_wait_rel", 32'(state_dbg), 32'd2);
        check("t2_count", 32'(step_count), 32'd1);
        cyc(1);
        check("t2_after", 32'(step_en), 32'd0);
        cyc(12);
        btn_step = 1'b0;
        cyc(5);
        check("t2_still_wait", 32'(state_dbg), 32'd2);
        cyc(5);
        check("t2_back_idle", 32'(state_dbg), 32'd0);
        check("t2_one_pulse", 32'(pulse_total - base), 32'd1);

        // 4. halt in the same clk as a tick
        auto_mode = 1'b1;
        slow_lvl  = 1'b0;
        cyc(4);
        check("t4_run", 32'(state_dbg), 32'd1);
        base = pulse_total;
        slow_lvl = 1'b1;
        cyc(2);
        halt = 1'b1;
        cyc(1);
        check("t4_no_pulse", 32'(step_en), 32'd0);
        check("t4_halted", 32'(state_dbg), 32'd3);
        halt     = 1'b0;
        slow_lvl = 1'b0;
        cyc(3);
        slow_lvl = 1'b1;
        cyc(5);
        auto_mode = 1'b0;
        btn_step  = 1'b1;
        cyc(10);
        btn_step = 1'b0;
        cyc(8);
        check("t4_still_halted", 32'(state_dbg), 32'd3);
        check("t4_pulses", 32'(pulse_total - base), 32'd0);
        check("t4_count_hold", 32'(step_count), 32'd1);

        // 5. counter wrap, then reset mid-count
        auto_mode = 1'b1;
        slow_lvl  = 1'b0;
        do_reset();
        cyc(4);
        for (int i = 0; i < 16; i++) begin
            slow_lvl = 1'b1;
            cyc(2);
            slow_lvl = 1'b0;
            cyc(2);
        end
        cyc(2);
        check("t5_wrap0", 32'(step_count), 32'd0);
        slow_lvl = 1'b1;
        cyc(2);
        slow_lvl = 1'b0;
        cyc(4);
        check("t5_wrap1", 32'(step_count), 32'd1);
        slow_lvl = 1'b1;
        cyc(3);
        check("t5_mid_pulse", 32'(step_en), 32'd1);
        check("t5_mid_count", 32'(step_count), 32'd2);
        reset = 1'b1;
        cyc(1);
        check("t5_rst_step_en", 32'(step_en), 32'd0);
        check("t5_rst_count",   32'(step_count), 32'd0);
        check("t5_rst_state",   32'(state_dbg), 32'd0);
        reset = 1'b0;
        cyc(2);

        check("never_consecutive", 32'(consec), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_step_pulse_gen
